fusion_seq: RTL and testbench

FUSION_SEQ -- requirements
Module: fusion_seq

---
 rtl/fusion_seq_if.sv | 40 ++++
 rtl/fusion_seq.sv | 155 +++++++++++++++
 tb/tb_fusion_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fusion_seq_if.sv
// Bundle of the operand, result and fusion-unit signals of fusion_seq.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid transfer is never withdrawn by the block once offered,
// and ready/valid from the block never depend combinationally on the partner.
interface fusion_seq_if #(parameter int ACC_W = 24);
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_in;
  logic [7:0]       op_weight;
  logic             op_s_in;
  logic             op_s_weight;
  logic             op_mode8;
  logic             op_last;
  logic [3:0]       fu_in;
  logic [3:0]       fu_weight;
  logic [2:0]       fu_in_width;
  logic [2:0]       fu_weight_width;
  logic             fu_s_in;
  logic             fu_s_weight;
  logic [17:0]      fu_psum;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

  // Upstream / environment side
  modport master (
    output op_valid, op_in, op_weight, op_s_in, op_s_weight, op_mode8, op_last,
    output res_ready, fu_psum,
    input  op_ready, res_valid, res_data,
    input  fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight
  );

  // Sequencer side
  modport slave (
    input  op_valid, op_in, op_weight, op_s_in, op_s_weight, op_mode8, op_last,
    input  res_ready, fu_psum,
    output op_ready, res_valid, res_data,
    output fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight
  );
endinterface

// File: rtl/fusion_seq.sv
// Sequences 8-bit (4 nibble passes) or 4-bit (1 pass) operand pairs through a
// 4x4 fusion unit and accumulates the shifted partial sums into a dot product.
module fusion_seq #(
  parameter int ACC_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  fusion_seq_if.slave  bus,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       p_q, p_d;
  logic [7:0]       in_q, in_d;
  logic [7:0]       w_q, w_d;
  logic             s_in_q, s_in_d;
  logic             s_w_q, s_w_d;
  logic             mode8_q, mode8_d;
  logic             last_q, last_d;
  logic             pv_q, pv_d;
  logic [3:0]       shift_q, shift_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic             in_hi;
  logic             w_hi;
  logic             last_pass;
  logic [3:0]       pass_shift;
  logic [ACC_W-1:0] psum_ext;

  // Nibble selection for the current pass: p[1] picks the input high nibble,
  // p[0] the weight high nibble; the shift is the sum of the two nibble weights.
  always_comb begin
    in_hi      = mode8_q & p_q[1];
    w_hi       = mode8_q & p_q[0];
    pass_shift = (in_hi ? 4'd4 : 4'd0) + (w_hi ? 4'd4 : 4'd0);
    last_pass  = mode8_q ? (p_q == 2'd3) : 1'b1;
    psum_ext   = ACC_W'($signed(bus.fu_psum));
  end

  // Fusion-unit operand drive; everything is zero outside RUN.
  always_comb begin
    bus.fu_in           = 4'd0;
    bus.fu_weight       = 4'd0;
    bus.fu_s_in         = 1'b0;
    bus.fu_s_weight     = 1'b0;
    bus.fu_in_width     = 3'b100;
    bus.fu_weight_width = 3'b100;
    if (state_q == RUN) begin
      bus.fu_in       = in_hi ? in_q[7:4] : in_q[3:0];
      bus.fu_weight   = w_hi  ? w_q[7:4]  : w_q[3:0];
      // Only the top nibble of a signed 8-bit operand carries the sign.
      bus.fu_s_in     = mode8_q ? (s_in_q & in_hi) : s_in_q;
      bus.fu_s_weight = mode8_q ? (s_w_q & w_hi)   : s_w_q;
    end
  end

  // Handshake and result outputs are pure functions of the state.
  always_comb begin
    bus.op_ready  = (state_q == IDLE);
    bus.res_valid = (state_q == OUT);
    bus.res_data  = (state_q == OUT) ? acc_q : '0;
    dbg_state     = state_q;
  end

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    in_d    = in_q;
    w_d     = w_q;
    s_in_d  = s_in_q;
    s_w_d   = s_w_q;
    mode8_d = mode8_q;
    last_d  = last_q;
    pv_d    = 1'b0;
    shift_d = shift_q;
    acc_d   = acc_q;

    // The psum of the pass issued two edges ago is ready now.
    if (pv_q) begin
      acc_d = acc_q + (psum_ext << shift_q);
    end

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          in_d    = bus.op_in;
          w_d     = bus.op_weight;
          s_in_d  = bus.op_s_in;
          s_w_d   = bus.op_s_weight;
          mode8_d = bus.op_mode8;
          last_d  = bus.op_last;
          p_d     = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        pv_d    = 1'b1;
        shift_d = pass_shift;
        p_d     = p_q + 2'd1;
        if (last_pass) begin
          p_d     = 2'd0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (bus.res_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 2'd0;
      in_q    <= 8'd0;
      w_q     <= 8'd0;
      s_in_q  <= 1'b0;
      s_w_q   <= 1'b0;
      mode8_q <= 1'b0;
      last_q  <= 1'b0;
      pv_q    <= 1'b0;
      shift_q <= 4'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      in_q    <= in_d;
      w_q     <= w_d;
      s_in_q  <= s_in_d;
      s_w_q   <= s_w_d;
      mode8_q <= mode8_d;
      last_q  <= last_d;
      pv_q    <= pv_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_fusion_seq.sv
// Directed bench for fusion_seq with a behavioural registered 4x4 fusion unit.
module tb_fusion_seq;

  localparam int ACC_W = 24;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fail;
  int n_consumed;

  logic [ACC_W-1:0] exp_q[$];

  fusion_seq_if #(.ACC_W(ACC_W)) bus();

  fusion_seq #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fusion unit: registered signed/unsigned 4x4 product, sign-extended to 18 bits.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.fu_psum <= 18'd0;
    else     bus.fu_psum <= $signed({bus.fu_s_in & bus.fu_in[3], bus.fu_in}) *
                            $signed({bus.fu_s_weight & bus.fu_weight[3], bus.fu_weight});
  end

  // Count result transfers.
  always @(posedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) n_consumed++;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pair(input logic [7:0] a, input logic [7:0] w,
                           input logic sa, input logic sw,
                           input logic m8, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("op_ready_before_send", {31'd0, bus.op_ready}, 32'd1);
    bus.op_valid    = 1'b1;
    bus.op_in       = a;
    bus.op_weight   = w;
    bus.op_s_in     = sa;
    bus.op_s_weight = sw;
    bus.op_mode8    = m8;
    bus.op_last     = last;
    @(posedge clk);
    #1;
    bus.op_valid    = 1'b0;
    bus.op_in       = 8'hA5;
    bus.op_weight   = 8'h5A;
  endtask

  // Wait for res_valid, counting edges since accept (elapsed already spent).
  task automatic wait_result(input string tag, input int lat_exp, input int elapsed);
    int n;
    logic [ACC_W-1:0] exp_data;
    n = elapsed;
    while (!bus.res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_latency"}, n, lat_exp);
    check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd1);
    check({tag, "_res_data"}, 32'(bus.res_data), 32'(exp_data));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check({tag, "_valid_after_consume"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_ready_after_consume"}, {31'd0, bus.op_ready}, 32'd1);
  endtask

  // Wait for op_ready after a non-last pair, counting edges since accept.
  task automatic wait_idle(input string tag, input int lat_exp);
    int n;
    n = 0;
    while (!bus.op_ready && n < 20) begin
      check({tag, "_no_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_idle_latency"}, n, lat_exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks        = 0;
    n_fail          = 0;
    n_consumed      = 0;
    rst             = 1'b1;
    bus.op_valid    = 1'b0;
    bus.op_in       = 8'd0;
    bus.op_weight   = 8'd0;
    bus.op_s_in     = 1'b0;
    bus.op_s_weight = 1'b0;
    bus.op_mode8    = 1'b0;
    bus.op_last     = 1'b0;
    bus.res_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_op_ready",  {31'd0, bus.op_ready},  32'd1);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data",  32'(bus.res_data),      32'd0);
    check("rst_fu_in",     {28'd0, bus.fu_in},     32'd0);
    check("rst_fu_weight", {28'd0, bus.fu_weight}, 32'd0);
    check("rst_fu_s",      {30'd0, bus.fu_s_in, bus.fu_s_weight}, 32'd0);
    check("rst_state",     {30'd0, dbg_state},     32'd0);
    check("fu_widths",     {26'd0, bus.fu_in_width, bus.fu_weight_width}, {26'd0, 6'b100100});
    rst = 1'b0;

    // res_ready while nothing is valid must be ignored
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_res_ready_ignored", {31'd0, bus.op_ready}, 32'd1);

    // 4-bit unsigned 7 x 9
    exp_q.push_back(24'd63);
    send_pair(8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t33_fu_in", {28'd0, bus.fu_in}, 32'd7);
    check("t33_fu_w",  {28'd0, bus.fu_weight}, 32'd9);
    check("t33_op_ready_busy", {31'd0, bus.op_ready}, 32'd0);
    wait_result("t33", 2, 0);
    consume("t33");

    // 8-bit unsigned 200 x 150 = 0xC8 x 0x96 with per-pass nibble checks
    exp_q.push_back(24'd30000);
    send_pair(8'd200, 8'd150, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t34_p0", {24'd0, bus.fu_in, bus.fu_weight}, 32'h86);
    @(posedge clk); #1;
    check("t34_p1", {24'd0, bus.fu_in, bus.fu_weight}, 32'h89);
    @(posedge clk); #1;
    check("t34_p2", {24'd0, bus.fu_in, bus.fu_weight}, 32'hC6);
    @(posedge clk); #1;
    check("t34_p3", {24'd0, bus.fu_in, bus.fu_weight}, 32'hC9);
    @(posedge clk); #1;
    check("t34_drain_fu_zero", {24'd0, bus.fu_in, bus.fu_weight}, 32'h00);
    wait_result("t34", 5, 4);
    consume("t34");

    // 8-bit signed -128 x 127; pass 2 flags: in high nibble signed, w low unsigned
    exp_q.push_back(24'hFFC080);
    send_pair(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t35_p0_flags", {30'd0, bus.fu_s_in, bus.fu_s_weight}, 32'd0);
    @(posedge clk); #1;
    check("t35_p1_flags", {30'd0, bus.fu_s_in, bus.fu_s_weight}, 32'd1);
    @(posedge clk); #1;
    check("t35_p2_flags", {30'd0, bus.fu_s_in, bus.fu_s_weight}, 32'd2);
    @(posedge clk); #1;
    check("t35_p3_flags", {30'd0, bus.fu_s_in, bus.fu_s_weight}, 32'd3);
    wait_result("t35", 5, 3);
    consume("t35");

    // three-pair dot product: 200 - 15 + 10000 = 10185
    n_consumed = 0;
    exp_q.push_back(24'd10185);
    send_pair(8'd10, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("t36a", 5);
    send_pair(8'hFD, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle("t36b", 5);
    send_pair(8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_result("t36", 5, 0);
    consume("t36");
    check("t36_one_result", n_consumed, 32'd1);

    // reset during RUN pass 2 abandons the operation
    send_pair(8'd55, 8'd66, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t37_in_run", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("t37_rst_op_ready",  {31'd0, bus.op_ready},  32'd1);
    check("t37_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("t37_rst_fu",        {24'd0, bus.fu_in, bus.fu_weight}, 32'd0);
    check("t37_rst_state",     {30'd0, dbg_state},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(24'd9);
    send_pair(8'd3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result("t37", 2, 0);
    consume("t37");

    // result held for 10 cycles with res_ready low (4-bit signed -2 x 3 = -6)
    exp_q.push_back(24'hFFFFFA);
    send_pair(8'h0E, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_result("t38", 2, 0);
    // the response queue was popped; hold checks use the known value
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t38_hold_valid", {31'd0, bus.res_valid}, 32'd1);
      check("t38_hold_data",  32'(bus.res_data), 32'h00FFFFFA);
      check("t38_hold_ready", {31'd0, bus.op_ready}, 32'd0);
      // op_valid during OUT must be ignored
      bus.op_valid = (i == 5);
    end
    bus.op_valid = 1'b0;
    consume("t38");
    check("t38_acc_cleared_state", {30'd0, dbg_state}, 32'd0);

    // acc cleared after consume: next result is independent
    exp_q.push_back(24'd1);
    send_pair(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result("acc_clear", 2, 0);
    consume("acc_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
